// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the seven-segment scan driver
// Holds the hex font (segments g..a, active-low), the all-segments-off
// pattern and a helper that builds the all-anodes-off mask for a given
// digit count. No ports.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Entry n is the glyph for nibble n; bit 6 = g ... bit 0 = a, 0 = lit.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0011000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Low num_digits bits set; callers truncate to their anode width.
    function automatic logic [63:0] anode_off(input int num_digits);
        anode_off = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < num_digits) begin
                anode_off[i] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// rtl/seg7_hex_font.sv - combinational nibble to seven-segment lookup
// Ports:
//   nibble_i  in  4  hex value to display
//   seg_o     out 7  segments g..a, active-low
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit seven-segment driver
// Latches a packed hex word and decimal points on LOAD_IN, then scans the
// digits with per-slot PWM brightness, leading-zero blanking and a global
// blank. Both outputs are registered (1-clock latency).
// Ports:
//   CLK             in  1             system clock
//   RESET           in  1             asynchronous, active-high reset
//   LOAD_IN         in  1             capture strobe for DIGITS_IN/DOTS_IN
//   DIGITS_IN       in  4*NUM_DIGITS  packed nibbles, [3:0] = digit 0
//   DOTS_IN         in  NUM_DIGITS    decimal points, active-high
//   LZB_IN          in  1             leading-zero blanking enable
//   BLANK_IN        in  1             force whole display dark
//   BRIGHT_IN       in  BRIGHT_W      duty level, all-ones = full on
//   SEG_SELECT_OUT  out NUM_DIGITS    anodes, active-low, at most one low
//   HEX_OUT         out 8             cathodes, active-low, [7] = dot
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_LOG2 = 16,
    parameter int BRIGHT_W     = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    LOAD_IN,
    input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
    input  logic [NUM_DIGITS-1:0]   DOTS_IN,
    input  logic                    LZB_IN,
    input  logic                    BLANK_IN,
    input  logic [BRIGHT_W-1:0]     BRIGHT_IN,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT
);

    localparam int                    IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = NUM_DIGITS'(anode_off(NUM_DIGITS));
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

    logic [REFRESH_LOG2-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
    logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   dot_q, dot_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [7:0]              hex_q, hex_d;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_dot;
    logic                    cur_lz;
    logic [6:0]              font_seg;
    logic                    pwm_on;

    // Counters and shadow registers
    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        dig_idx_d  = dig_idx_q;
        if (&slot_cnt_q) begin
            dig_idx_d = (dig_idx_q == LAST_IDX) ? '0 : dig_idx_q + 1'b1;
        end
        digit_d = LOAD_IN ? DIGITS_IN : digit_q;
        dot_d   = LOAD_IN ? DOTS_IN   : dot_q;
    end

    // A digit is a leading zero when it and every digit to its left are 0.
    // Digit 0 is excluded so an all-zero word still shows a single "0".
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run & (digit_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dot = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_idx_q == IDX_W'(i)) begin
                cur_nib = digit_q[4*i +: 4];
                cur_dot = dot_q[i];
                cur_lz  = lz_blank[i];
            end
        end
    end

    seg7_hex_font u_font (
        .nibble_i (cur_nib),
        .seg_o    (font_seg)
    );

    // Slot 0 keeps the anode off so the cathodes settle on the new digit
    // before it lights; the top slot bits against BRIGHT_IN set the duty.
    assign pwm_on = (slot_cnt_q[REFRESH_LOG2-1 -: BRIGHT_W] <= BRIGHT_IN)
                 && (slot_cnt_q != '0);

    always_comb begin
        anode_d = ANODE_OFF;
        hex_d   = 8'hFF;
        if (!BLANK_IN) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                anode_d[i] = !(pwm_on && (dig_idx_q == IDX_W'(i)));
            end
            hex_d = {~cur_dot, (LZB_IN && cur_lz) ? SEG_OFF : font_seg};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            slot_cnt_q <= '0;
            dig_idx_q  <= '0;
            digit_q    <= '0;
            dot_q      <= '0;
            anode_q    <= ANODE_OFF;
            hex_q      <= 8'hFF;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            dig_idx_q  <= dig_idx_d;
            digit_q    <= digit_d;
            dot_q      <= dot_d;
            anode_q    <= anode_d;
            hex_q      <= hex_d;
        end
    end

    assign SEG_SELECT_OUT = anode_q;
    assign HEX_OUT        = hex_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        LOAD_IN = 1'b0;
    logic [15:0] DIGITS_IN = '0;
    logic [3:0]  DOTS_IN = '0;
    logic        LZB_IN = 1'b0;
    logic        BLANK_IN = 1'b0;
    logic [2:0]  BRIGHT_IN = 3'd7;
    logic [3:0]  SEG_SELECT_OUT;
    logic [7:0]  HEX_OUT;

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_LOG2 (4),
        .BRIGHT_W     (3)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .LOAD_IN        (LOAD_IN),
        .DIGITS_IN      (DIGITS_IN),
        .DOTS_IN        (DOTS_IN),
        .LZB_IN         (LZB_IN),
        .BLANK_IN       (BLANK_IN),
        .BRIGHT_IN      (BRIGHT_IN),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .HEX_OUT        (HEX_OUT)
    );

    typedef struct {
        int          e;
        logic [3:0]  an;
        logic [7:0]  hex;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    always #5 CLK = ~CLK;

    // Clock edges since reset release; edge e shows the state before edge e.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic push(input int e, input logic [3:0] an, input logic [7:0] hex,
                        input string name);
        exp_t x;
        x.e = e; x.an = an; x.hex = hex; x.name = name;
        sb.push_back(x);
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: pops every expectation whose edge has been reached.
    always @(negedge CLK) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].e <= edge_n) begin
            x = sb.pop_front();
            checks++;
            if (x.e != edge_n) begin
                errors++;
                $display("FAIL %s: expected at edge %0d, monitor at edge %0d", x.name, x.e, edge_n);
            end else begin
                if (SEG_SELECT_OUT !== x.an) begin
                    errors++;
                    $display("FAIL %s anode @%0d: got %b want %b", x.name, x.e, SEG_SELECT_OUT, x.an);
                end
                checks++;
                if (HEX_OUT !== x.hex) begin
                    errors++;
                    $display("FAIL %s hex @%0d: got %b want %b", x.name, x.e, HEX_OUT, x.hex);
                end
            end
        end
    end

    initial begin
        push(0, 4'b1111, 8'hFF, "reset_init");
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        push(1, 4'b1111, 8'hC0, "rel_slot0");
        push(2, 4'b1110, 8'hC0, "rel_slot1");

        // Basic scan of 12AF with dot on digit 2
        wait_edge(2);
        LOAD_IN = 1'b1; DIGITS_IN = 16'h12AF; DOTS_IN = 4'b0100;
        wait_edge(3);
        LOAD_IN = 1'b0;
        push(4,  4'b1110, 8'h8E, "scan_d0_load");
        push(5,  4'b1110, 8'h8E, "scan_d0");
        push(16, 4'b1110, 8'h8E, "scan_d0_last");
        push(17, 4'b1111, 8'h88, "scan_d1_guard");
        push(18, 4'b1101, 8'h88, "scan_d1");
        push(32, 4'b1101, 8'h88, "scan_d1_last");
        push(33, 4'b1111, 8'h24, "scan_d2_guard");
        push(34, 4'b1011, 8'h24, "scan_d2");
        push(48, 4'b1011, 8'h24, "scan_d2_last");
        push(49, 4'b1111, 8'hF9, "scan_d3_guard");
        push(50, 4'b0111, 8'hF9, "scan_d3");
        push(64, 4'b0111, 8'hF9, "scan_d3_last");

        // Brightness
        wait_edge(64);
        BRIGHT_IN = 3'd0;
        push(66, 4'b1110, 8'h8E, "br0_slot1");
        push(67, 4'b1111, 8'h8E, "br0_slot2");
        push(82, 4'b1101, 8'h88, "br0_d1_slot1");
        push(83, 4'b1111, 8'h88, "br0_d1_slot2");
        wait_edge(96);
        BRIGHT_IN = 3'd3;
        push(98,  4'b1011, 8'h24, "br3_slot1");
        push(104, 4'b1011, 8'h24, "br3_slot7");
        push(105, 4'b1111, 8'h24, "br3_slot8");
        wait_edge(112);
        BRIGHT_IN = 3'd7;

        // Leading-zero blanking
        wait_edge(128);
        LZB_IN = 1'b1; LOAD_IN = 1'b1; DIGITS_IN = 16'h0040; DOTS_IN = 4'b1000;
        wait_edge(129);
        LOAD_IN = 1'b0;
        push(130, 4'b1110, 8'hC0, "lzb_d0_first");
        push(131, 4'b1110, 8'hC0, "lzb_d0");
        push(147, 4'b1101, 8'h99, "lzb_d1");
        push(163, 4'b1011, 8'hFF, "lzb_d2");
        push(179, 4'b0111, 8'h7F, "lzb_d3_dot");
        wait_edge(192);
        LOAD_IN = 1'b1; DIGITS_IN = 16'h0000; DOTS_IN = 4'b0000;
        wait_edge(193);
        LOAD_IN = 1'b0;
        push(195, 4'b1110, 8'hC0, "lz0_d0");
        push(211, 4'b1101, 8'hFF, "lz0_d1");
        push(227, 4'b1011, 8'hFF, "lz0_d2");
        push(243, 4'b0111, 8'hFF, "lz0_d3");

        // Load mid-slot
        wait_edge(256);
        LZB_IN = 1'b0; LOAD_IN = 1'b1; DIGITS_IN = 16'h1111;
        wait_edge(257);
        LOAD_IN = 1'b0;
        push(278, 4'b1101, 8'hF9, "mid_before");
        push(279, 4'b1101, 8'hF9, "mid_load_edge");
        push(280, 4'b1101, 8'hA4, "mid_after");
        wait_edge(278);
        LOAD_IN = 1'b1; DIGITS_IN = 16'h2222;
        wait_edge(279);
        LOAD_IN = 1'b0;

        // Blank override for 40 clocks
        wait_edge(290);
        BLANK_IN = 1'b1;
        push(291, 4'b1111, 8'hFF, "blank_first");
        push(300, 4'b1111, 8'hFF, "blank_mid");
        push(310, 4'b1111, 8'hFF, "blank_mid2");
        push(321, 4'b1111, 8'hFF, "blank_mid3");
        push(330, 4'b1111, 8'hFF, "blank_last");
        push(331, 4'b1110, 8'hA4, "unblank_d0");
        push(337, 4'b1111, 8'hA4, "unblank_d1_guard");
        push(338, 4'b1101, 8'hA4, "unblank_d1");
        push(340, 4'b1101, 8'hA4, "pre_reset_lit");
        wait_edge(330);
        BLANK_IN = 1'b0;

        // Asynchronous reset mid-slot
        wait_edge(341);
        #2 RESET = 1'b1;
        push(0, 4'b1111, 8'hFF, "reset_async");
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        push(1, 4'b1111, 8'hC0, "rerel_slot0");
        push(2, 4'b1110, 8'hC0, "rerel_slot1");

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
